// File: rtl/iman_emulator_if.sv
// Bundles the iman_emulator configuration inputs and magnet-line outputs.
// The stimulus side drives the configuration; the emulator drives the line and status outputs.
interface iman_emulator_if #(
    parameter int PERIOD_W = 24
);
    logic                enable;
    logic [PERIOD_W-1:0] periodo;
    logic [PERIOD_W-1:0] ancho;
    logic                rebote_en;
    logic                iman;
    logic                revolucion;
    logic [15:0]         vueltas;
    logic                cfg_error;

    modport master (
        output enable, periodo, ancho, rebote_en,
        input  iman, revolucion, vueltas, cfg_error
    );

    modport slave (
        input  enable, periodo, ancho, rebote_en,
        output iman, revolucion, vueltas, cfg_error
    );
endinterface

// File: rtl/iman_emulator.sv
// Wheel-magnet pulse generator: optional contact-bounce burst, then a clean pulse, once per period.
// All outputs are registered; a start sampled at edge n shows on iman in cycle n+1. There is no backpressure.
module iman_emulator #(
    parameter int PERIOD_W      = 24,
    parameter int BOUNCE_COUNT  = 3,
    parameter int BOUNCE_CYCLES = 4
) (
    input  logic           clock,
    input  logic           reset_n,
    iman_emulator_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BOUNCE, HIGH, LOW} state_t;

    localparam logic [PERIOD_W-1:0] ONE   = PERIOD_W'(1);
    localparam logic [PERIOD_W-1:0] BL_ON = PERIOD_W'(2 * BOUNCE_COUNT * BOUNCE_CYCLES);
    localparam logic [PERIOD_W-1:0] BC    = PERIOD_W'(BOUNCE_CYCLES);

    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] p_q, p_d;
    logic [PERIOD_W-1:0] w_q, w_d;
    logic                be_q, be_d;
    logic                iman_q, iman_d;
    logic                rev_q, rev_d;
    logic                err_q, err_d;
    logic [15:0]         vueltas_q, vueltas_d;

    logic [PERIOD_W-1:0] bl_in, bl_sh;
    logic [PERIOD_W+1:0] need;
    logic                cfg_ok, sample;

    always_comb begin
        bl_in  = bus.rebote_en ? BL_ON : '0;
        bl_sh  = be_q ? BL_ON : '0;
        // Widened so a large ancho cannot wrap and masquerade as a short, valid config.
        need   = {2'b00, bl_in} + {2'b00, bus.ancho} + (PERIOD_W+2)'(1);
        cfg_ok = (bus.ancho != '0) && ({2'b00, bus.periodo} >= need);
        sample = (state_q == IDLE) || ((state_q == LOW) && (cnt_q == p_q - ONE));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + ONE;
        p_d     = p_q;
        w_d     = w_q;
        be_d    = be_q;
        err_d   = err_q;
        if (sample) begin
            cnt_d = '0;
            if (bus.enable && cfg_ok) begin
                p_d     = bus.periodo;
                w_d     = bus.ancho;
                be_d    = bus.rebote_en;
                err_d   = 1'b0;
                state_d = bus.rebote_en ? BOUNCE : HIGH;
            end else begin
                if (bus.enable) begin
                    err_d = 1'b1;
                end
                state_d = IDLE;
            end
        end else begin
            case (state_q)
                BOUNCE: if (cnt_q == bl_sh - ONE) state_d = HIGH;
                HIGH:   if (cnt_q == bl_sh + w_q - ONE) state_d = LOW;
                default: ;
            endcase
        end

        // Outputs are a function of the upcoming state so they line up with it after the edge.
        iman_d    = (state_d == HIGH) ||
                    ((state_d == BOUNCE) && (((cnt_d / BC) & ONE) == '0));
        rev_d     = (state_d == HIGH) && (state_q != HIGH);
        vueltas_d = vueltas_q + {15'd0, rev_d};
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            p_q       <= '0;
            w_q       <= '0;
            be_q      <= 1'b0;
            iman_q    <= 1'b0;
            rev_q     <= 1'b0;
            err_q     <= 1'b0;
            vueltas_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            p_q       <= p_d;
            w_q       <= w_d;
            be_q      <= be_d;
            iman_q    <= iman_d;
            rev_q     <= rev_d;
            err_q     <= err_d;
            vueltas_q <= vueltas_d;
        end
    end

    assign bus.iman       = iman_q;
    assign bus.revolucion = rev_q;
    assign bus.vueltas    = vueltas_q;
    assign bus.cfg_error  = err_q;
endmodule

// File: tb/tb_iman_emulator.sv
// Scoreboard bench: a period-level waveform model queues the expected outputs, a monitor compares every cycle.
module tb_iman_emulator;
    localparam int PW  = 24;
    localparam int BN  = 3;
    localparam int BC  = 4;
    localparam int BLF = 2 * BN * BC;

    typedef struct packed {
        logic        iman;
        logic        rev;
        logic [15:0] vueltas;
        logic        err;
    } obs_t;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    iman_emulator_if #(.PERIOD_W(PW)) bus ();

    iman_emulator #(
        .PERIOD_W(PW),
        .BOUNCE_COUNT(BN),
        .BOUNCE_CYCLES(BC)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus)
    );

    obs_t        exp_q[$];
    obs_t        plan[$];
    logic [15:0] m_v   = 16'd0;
    logic        m_err = 1'b0;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          waited   = 0;

    // Builds one whole period of expected outputs (or a single idle cycle) from the sampled config.
    task automatic fill_plan();
        int   p, w, bl;
        logic ok;
        obs_t e;
        p  = int'(bus.periodo);
        w  = int'(bus.ancho);
        bl = bus.rebote_en ? BLF : 0;
        ok = (w >= 1) && (p >= bl + w + 1);
        if (bus.enable && !ok) m_err = 1'b1;
        if (!bus.enable || !ok) begin
            e.iman    = 1'b0;
            e.rev     = 1'b0;
            e.vueltas = m_v;
            e.err     = m_err;
            plan.push_back(e);
        end else begin
            m_err = 1'b0;
            for (int i = 0; i < p; i++) begin
                if (i == bl) m_v = m_v + 16'd1;
                e.iman    = (i < bl) ? ((i / BC) % 2 == 0) : (i < bl + w);
                e.rev     = (i == bl);
                e.vueltas = m_v;
                e.err     = 1'b0;
                plan.push_back(e);
            end
        end
    endtask

    always @(posedge clock) begin
        obs_t e;
        if (!reset_n) begin
            plan.delete();
            m_v   = 16'd0;
            m_err = 1'b0;
            e     = '0;
        end else begin
            if (plan.size() == 0) fill_plan();
            e = plan.pop_front();
        end
        exp_q.push_back(e);
    end

    always @(negedge clock) begin
        if (exp_q.size() != 0) begin
            obs_t e, a;
            e = exp_q.pop_front();
            a = {bus.iman, bus.revolucion, bus.vueltas, bus.cfg_error};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL outputs t=%0t actual iman=%b rev=%b vueltas=%0d err=%b required iman=%b rev=%b vueltas=%0d err=%b",
                         $time, a.iman, a.rev, a.vueltas, a.err, e.iman, e.rev, e.vueltas, e.err);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic cfg(input logic en, input int p, input int w, input logic rb);
        bus.enable    = en;
        bus.periodo   = PW'(p);
        bus.ancho     = PW'(w);
        bus.rebote_en = rb;
    endtask

    initial begin
        reset_n = 1'b0;
        cfg(1'b1, 100, 10, 1'b0);
        cyc(5);
        n_checks++;
        if (bus.iman !== 1'b0 || bus.revolucion !== 1'b0 || bus.vueltas !== 16'd0 || bus.cfg_error !== 1'b0) begin
            n_fail++;
            $display("FAIL reset t=%0t actual iman=%b rev=%b vueltas=%0d err=%b required all zero",
                     $time, bus.iman, bus.revolucion, bus.vueltas, bus.cfg_error);
        end
        reset_n = 1'b1;
        waited = 0;
        while (bus.revolucion !== 1'b1 && waited < 200) begin
            cyc(1);
            waited++;
        end
        n_checks++;
        if (bus.revolucion !== 1'b1) begin
            n_fail++;
            $display("FAIL wait t=%0t no revolucion within %0d cycles of reset release", $time, waited);
        end
        cyc(320 - waited);              // clean pulses, 100-cycle period
        bus.rebote_en = 1'b1;
        cyc(321);                       // bounce burst before each pulse
        bus.periodo = PW'(50);          // lands mid-period
        cyc(250);
        cfg(1'b1, 30, 10, 1'b1);        // too short for bounce + pulse
        cyc(150);
        bus.periodo = PW'(35);          // minimum legal period
        cyc(150);
        bus.enable = 1'b0;
        cyc(60);
        cfg(1'b1, 60, 10, 1'b0);
        cyc(6);
        bus.enable = 1'b0;              // dropped inside the high phase
        cyc(100);
        bus.enable = 1'b1;
        cyc(6);
        reset_n = 1'b0;                 // reset inside the high phase
        cyc(2);
        reset_n = 1'b1;
        bus.enable = 1'b0;
        cyc(20);
        for (int k = 0; k < 40; k++) begin
            cfg($urandom_range(0, 9) != 0, $urandom_range(1, 70),
                $urandom_range(0, 20), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 15) == 0) begin
                reset_n = 1'b0;
                cyc(1);
                reset_n = 1'b1;
            end
            cyc($urandom_range(1, 120));
        end
        bus.enable = 1'b0;
        cyc(2);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/iman_emulator.md
# iman_emulator

Wheel-magnet pulse generator: drives the same single-bit `iman` line that the speedometer's debounce front end samples, producing one magnet pulse per programmed wheel revolution. Optional contact-bounce injection precedes each clean pulse so the debounce → impulse → displacement/velocity chain can be exercised on the bench or looped back on the board. It is the transmitter counterpart to the magnet receiver path.

## Interface
- `PERIOD_W`, 24: width of the period/width counters.
- `BOUNCE_COUNT`, 3: bounce high/low pairs injected before the clean pulse.
- `BOUNCE_CYCLES`, 4: cycles per bounce half-phase.
- `clock`  in  1  single system clock, all logic on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `enable`  in  1  run request.
- `periodo`  in  PERIOD_W  cycles between successive pulse starts (one revolution).
- `ancho`  in  PERIOD_W  clean high width in cycles.
- `rebote_en`  in  1  inject bounce before each clean pulse.
- `iman`  out  1  emulated magnet line, registered.
- `revolucion`  out  1  one-cycle strobe on the first cycle of each clean high phase.
- `vueltas`  out  16  revolution count, wraps 65535 → 0.
- `cfg_error`  out  1  last sampled configuration invalid.

## Operation
- BL = `rebote_en` ? 2·BOUNCE_COUNT·BOUNCE_CYCLES : 0 (evaluated with the sampled `rebote_en`).
- Config valid iff `ancho` ≥ 1 and `periodo` ≥ BL + `ancho` + 1.
- States: IDLE, BOUNCE, HIGH, LOW. Period counter `cnt` counts 0 … P−1 within each period; P, W and bounce enable are shadow copies.
- Sample point: any cycle in IDLE, or the last cycle of LOW (`cnt` = P−1). At a sample point:
  - `enable`=1, config valid: load shadows (P, W, bounce enable), clear `cfg_error`, reset `cnt` to 0, go to BOUNCE if bounce enabled, else HIGH.
  - `enable`=1, config invalid: set `cfg_error`, go to or stay in IDLE.
  - `enable`=0: go to or stay in IDLE; `cfg_error` holds.
- Inputs changing mid-period have no effect until the next sample point.
- BOUNCE: `iman` = 1 when floor(`cnt`/BOUNCE_CYCLES) is even, else 0. Leave for HIGH after BL cycles.
- HIGH: `iman` = 1 for W cycles. On entry, pulse `revolucion` and increment `vueltas`.
- LOW: `iman` = 0 until `cnt` = P−1.
- IDLE: `iman` = 0.
- Deasserting `enable` never truncates a period; the period in progress completes.
- `vueltas` is not cleared by `enable`, only by reset.

## Timing
- Reset values: state IDLE, `cnt` 0, `iman` 0, `revolucion` 0, `vueltas` 0, `cfg_error` 0, shadows 0.
- Reset asserted in any state takes effect on the next edge, even mid-pulse: `iman` = 0 on the following cycle.
- Start latency: `enable` sampled high in IDLE at edge n → `iman` = 1 at cycle n+1. This is the first bounce-high cycle, or the first clean-high cycle if bounce is off.
- Consecutive period starts are exactly P cycles apart; no idle gap between periods while enabled.
- Clean rising edge (and `revolucion`) at `cnt` = BL of each period. `revolucion` is high for exactly 1 cycle, coincident with the first HIGH cycle of `iman`.
- `vueltas` updates on the same edge that raises `revolucion`.
- `cfg_error` is registered: valid one cycle after the rejecting sample point.
- Minimum legal period P = BL + 2 (W = 1): 1 low cycle per period.

## Test plan
- Reset: hold `reset_n`=0 for 5 cycles with `enable`=1 → `iman`, `revolucion`, `cfg_error` = 0 and `vueltas` = 0 throughout and on the first cycle after release.
- No bounce: `periodo`=100, `ancho`=10, `rebote_en`=0, `enable`=1 → `iman` high 10 cycles / low 90, rising edges exactly 100 apart, `revolucion` on each rise, `vueltas` reads 1, 2, 3 after three periods.
- Bounce: `periodo`=100, `ancho`=10, `rebote_en`=1 → per period: 4 high / 4 low ×3, then 10 high, then 66 low. `revolucion` at `cnt`=24; exactly one `vueltas` increment per period. Feeding this through the debounce + impulse chain yields one impulse per period.
- Mid-period change: running at `periodo`=100, change to 50 at `cnt`=40 → current period still 100 cycles; subsequent rising edges 50 apart.
- Invalid config: `periodo`=30, `ancho`=10, `rebote_en`=1 (needs ≥35) → `cfg_error`=1, `iman` stays 0. Changing `periodo` to 35 → `cfg_error` clears, pulses every 35 cycles with 1 low cycle.
- Stop/reset mid-operation: drop `enable` at `cnt`=5 of the HIGH phase → period completes, `iman` stays 0 afterwards, `vueltas` holds. Repeat with `reset_n`=0 at that point → `iman` = 0 on the next cycle and `vueltas` = 0.
